writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 143 ++++++++++++++
 tb/tb_writeback_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: picks a result source, extracts and extends MEM loads,
// registers the register-file write, counts retired instructions and
// freezes after a break instruction retires.
module writeback_unit #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSRC = 4,
  parameter int CW   = 32,
  localparam int SW  = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int OW  = $clog2(DW / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_flush,
  input  logic               in_we,
  input  logic               in_brk,
  input  logic [AW-1:0]      in_waddr,
  input  logic [SW-1:0]      in_src_sel,
  input  logic [NSRC*DW-1:0] in_src_data,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_signed,
  input  logic [OW-1:0]      in_ld_off,
  output logic               in_ready,
  output logic               wb_en,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  output logic               halted,
  output logic [CW-1:0]      retire_cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           wbEn_q;
  logic [AW-1:0]  wbAddr_q;
  logic [DW-1:0]  wbData_q, wbData_d;
  logic [CW-1:0]  retireCnt_q;

  logic           accept;
  logic           selInRange;
  logic           doWrite;
  logic [DW-1:0]  selData;
  logic [DW-1:0]  memWord;
  logic [DW-1:0]  ldExt;
  logic [OW+2:0]  byteBase, halfBase, wordBase;
  logic [7:0]     ldByte;
  logic [15:0]    ldHalf;
  logic [31:0]    ldWord;

  assign accept     = in_valid & in_ready & ~in_flush;
  assign selInRange = ({1'b0, in_src_sel} < (SW+1)'(NSRC));
  assign doWrite    = accept & in_we & ~in_brk & (in_waddr != '0) & selInRange;

  // Bit offsets of the addressed byte/half/word; low offset bits of
  // misaligned half and word loads are masked away rather than trapped.
  assign byteBase = {in_ld_off, 3'b000};
  assign halfBase = byteBase & ~((OW+3)'(15));
  assign wordBase = byteBase & ~((OW+3)'(31));

  assign memWord = in_src_data[DW +: DW];
  assign ldByte  = memWord[byteBase +: 8];
  assign ldHalf  = memWord[halfBase +: 16];
  assign ldWord  = memWord[wordBase +: 32];

  // State register: reset always lands in RUN, even from HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only an accepted break leaves RUN, and nothing leaves HALTED.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && accept && in_brk) begin
      state_d = HALTED;
    end
  end

  // State-derived outputs: the stage stops taking input once halted.
  always_comb begin
    in_ready = (state_q == RUN);
    halted   = (state_q == HALTED);
  end

  // Plain source multiplexer over the sources that actually exist.
  always_comb begin
    selData = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_src_sel == SW'(k)) begin
        selData = in_src_data[k*DW +: DW];
      end
    end
  end

  // Load extraction from the MEM source, widened with sign or zero fill.
  always_comb begin
    ldExt = memWord;
    case (in_ld_size)
      2'b00:   ldExt = in_ld_signed ? DW'($signed(ldByte)) : DW'(ldByte);
      2'b01:   ldExt = in_ld_signed ? DW'($signed(ldHalf)) : DW'(ldHalf);
      2'b10:   ldExt = in_ld_signed ? DW'($signed(ldWord)) : DW'(ldWord);
      default: ldExt = memWord;
    endcase
  end

  // Only the MEM source goes through load extraction.
  always_comb begin
    wbData_d = selData;
    if (in_src_sel == SW'(1)) begin
      wbData_d = ldExt;
    end
  end

  // Registered write port and retire counter; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbEn_q      <= 1'b0;
      wbAddr_q    <= '0;
      wbData_q    <= '0;
      retireCnt_q <= '0;
    end else begin
      wbEn_q <= doWrite;
      if (doWrite) begin
        wbAddr_q <= in_waddr;
        wbData_q <= wbData_d;
      end
      retireCnt_q <= retireCnt_q + CW'(accept);
    end
  end

  assign wb_en      = wbEn_q;
  assign wb_addr    = wbAddr_q;
  assign wb_data    = wbData_q;
  assign retire_cnt = retireCnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit: a default instance plus a narrow
// counter instance (CW=4) and a three-source instance (NSRC=3) fed in parallel.
module tb_writeback_unit;

  logic         clk;
  logic         rst;
  logic         inValid, inFlush, inWe, inBrk, inLdSigned;
  logic [4:0]   inWaddr;
  logic [1:0]   inSrcSel, inLdSize, inLdOff;
  logic [127:0] srcData;

  logic         readyM, wbEnM, haltedM;
  logic [4:0]   wbAddrM;
  logic [31:0]  wbDataM, cntM;

  logic         readyW, wbEnW, haltedW;
  logic [4:0]   wbAddrW;
  logic [31:0]  wbDataW;
  logic [3:0]   cntW;

  logic         readyS, wbEnS, haltedS;
  logic [4:0]   wbAddrS;
  logic [31:0]  wbDataS, cntS;

  int checkCount = 0;
  int errorCount = 0;

  writeback_unit dutMain (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_flush(inFlush), .in_we(inWe),
    .in_brk(inBrk), .in_waddr(inWaddr), .in_src_sel(inSrcSel), .in_src_data(srcData),
    .in_ld_size(inLdSize), .in_ld_signed(inLdSigned), .in_ld_off(inLdOff),
    .in_ready(readyM), .wb_en(wbEnM), .wb_addr(wbAddrM), .wb_data(wbDataM),
    .halted(haltedM), .retire_cnt(cntM)
  );

  writeback_unit #(.CW(4)) dutWrap (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_flush(inFlush), .in_we(inWe),
    .in_brk(inBrk), .in_waddr(inWaddr), .in_src_sel(inSrcSel), .in_src_data(srcData),
    .in_ld_size(inLdSize), .in_ld_signed(inLdSigned), .in_ld_off(inLdOff),
    .in_ready(readyW), .wb_en(wbEnW), .wb_addr(wbAddrW), .wb_data(wbDataW),
    .halted(haltedW), .retire_cnt(cntW)
  );

  writeback_unit #(.NSRC(3)) dutSrc3 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_flush(inFlush), .in_we(inWe),
    .in_brk(inBrk), .in_waddr(inWaddr), .in_src_sel(inSrcSel), .in_src_data(srcData[95:0]),
    .in_ld_size(inLdSize), .in_ld_signed(inLdSigned), .in_ld_off(inLdOff),
    .in_ready(readyS), .wb_en(wbEnS), .wb_addr(wbAddrS), .wb_data(wbDataS),
    .halted(haltedS), .retire_cnt(cntS)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction onto the shared input bus.
  task automatic applyStimulus(input logic valid, input logic flush, input logic we,
                               input logic brk, input logic [4:0] waddr,
                               input logic [1:0] sel, input logic [1:0] size,
                               input logic sgn, input logic [1:0] off);
    inValid    = valid;
    inFlush    = flush;
    inWe       = we;
    inBrk      = brk;
    inWaddr    = waddr;
    inSrcSel   = sel;
    inLdSize   = size;
    inLdSigned = sgn;
    inLdOff    = off;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous reset with an idle bus.
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 5'd0, 2'd0, 2'd0, 0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  // Directed sequence; source data is {link, IO, MEM, ALU}.
  initial begin
    rst     = 1'b1;
    srcData = {32'hDEAD_0003, 32'hCAFE_BABE, 32'h80FF_7F01, 32'h1234_5678};
    applyStimulus(1, 0, 1, 0, 5'd8, 2'd0, 2'd0, 0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset wb_en", wbEnM, 0);
    checkOutput("reset wb_addr", wbAddrM, 0);
    checkOutput("reset wb_data", wbDataM, 0);
    checkOutput("reset halted", haltedM, 0);
    checkOutput("reset retire_cnt", cntM, 0);
    checkOutput("reset in_ready", readyM, 1);

    applyStimulus(1, 0, 1, 0, 5'd8, 2'd0, 2'd0, 0, 2'd0);
    tick();
    checkOutput("alu wb_en", wbEnM, 1);
    checkOutput("alu wb_addr", wbAddrM, 8);
    checkOutput("alu wb_data", wbDataM, 32'h1234_5678);
    checkOutput("alu retire_cnt", cntM, 1);

    applyStimulus(1, 0, 1, 0, 5'd5, 2'd1, 2'b00, 1, 2'd3);
    tick();
    checkOutput("byte signed data", wbDataM, 32'hFFFF_FF80);
    checkOutput("byte signed addr", wbAddrM, 5);

    applyStimulus(1, 0, 1, 0, 5'd5, 2'd1, 2'b00, 0, 2'd3);
    tick();
    checkOutput("byte unsigned data", wbDataM, 32'h0000_0080);

    applyStimulus(1, 0, 1, 0, 5'd6, 2'd1, 2'b01, 1, 2'd3);
    tick();
    checkOutput("half misaligned signed", wbDataM, 32'hFFFF_80FF);

    applyStimulus(1, 0, 1, 0, 5'd6, 2'd1, 2'b01, 1, 2'd1);
    tick();
    checkOutput("half low positive", wbDataM, 32'h0000_7F01);

    applyStimulus(1, 0, 1, 0, 5'd7, 2'd1, 2'b11, 0, 2'd2);
    tick();
    checkOutput("full load", wbDataM, 32'h80FF_7F01);

    applyStimulus(1, 0, 1, 0, 5'd7, 2'd1, 2'b10, 1, 2'd3);
    tick();
    checkOutput("word misaligned", wbDataM, 32'h80FF_7F01);
    checkOutput("word retire_cnt", cntM, 7);

    applyStimulus(1, 0, 1, 0, 5'd31, 2'd2, 2'b00, 1, 2'd3);
    tick();
    checkOutput("io data", wbDataM, 32'hCAFE_BABE);
    checkOutput("io addr", wbAddrM, 31);

    applyStimulus(1, 0, 1, 0, 5'd1, 2'd3, 2'b00, 1, 2'd0);
    tick();
    checkOutput("link data", wbDataM, 32'hDEAD_0003);
    checkOutput("link retire_cnt", cntM, 9);

    applyStimulus(1, 0, 1, 0, 5'd0, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("zero reg wb_en", wbEnM, 0);
    checkOutput("zero reg holds data", wbDataM, 32'hDEAD_0003);
    checkOutput("zero reg holds addr", wbAddrM, 1);
    checkOutput("zero reg retire_cnt", cntM, 10);

    applyStimulus(1, 0, 0, 0, 5'd4, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("no-we wb_en", wbEnM, 0);
    checkOutput("no-we retire_cnt", cntM, 11);

    applyStimulus(1, 1, 1, 0, 5'd4, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("flush wb_en", wbEnM, 0);
    checkOutput("flush retire_cnt", cntM, 11);

    applyStimulus(1, 1, 1, 1, 5'd4, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("flush brk halted", haltedM, 0);
    checkOutput("flush brk retire_cnt", cntM, 11);

    applyStimulus(0, 0, 1, 0, 5'd4, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("idle wb_en", wbEnM, 0);
    checkOutput("idle retire_cnt", cntM, 11);

    applyStimulus(1, 0, 1, 1, 5'd6, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("brk wb_en", wbEnM, 0);
    checkOutput("brk halted", haltedM, 1);
    checkOutput("brk in_ready", readyM, 0);
    checkOutput("brk retire_cnt", cntM, 12);

    applyStimulus(1, 0, 1, 0, 5'd9, 2'd0, 2'b00, 0, 2'd0);
    tick();
    checkOutput("halted ignores wb_en", wbEnM, 0);
    checkOutput("halted ignores cnt", cntM, 12);
    checkOutput("halted stays", haltedM, 1);
    checkOutput("halted holds addr", wbAddrM, 1);

    resetDut();
    checkOutput("rst from halt halted", haltedM, 0);
    checkOutput("rst from halt in_ready", readyM, 1);
    checkOutput("rst from halt cnt", cntM, 0);
    checkOutput("rst from halt data", wbDataM, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 0, 1, 0, 5'd2, 2'd0, 2'b00, 0, 2'd0);
      tick();
    end
    checkOutput("wrap cw4 cnt", cntW, 1);
    checkOutput("wide cnt 17", cntM, 17);
    checkOutput("nsrc3 cnt 17", cntS, 17);

    applyStimulus(1, 0, 1, 0, 5'd9, 2'd3, 2'b00, 0, 2'd0);
    tick();
    checkOutput("nsrc3 sel3 wb_en", wbEnS, 0);
    checkOutput("nsrc3 sel3 cnt", cntS, 18);
    checkOutput("nsrc4 sel3 wb_en", wbEnM, 1);
    checkOutput("nsrc3 sel3 holds addr", wbAddrS, 2);

    applyStimulus(0, 0, 0, 0, 5'd0, 2'd0, 2'b00, 0, 2'd0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
